// File: rtl/license_plate_recognizer.sv
// ---------------------------------------------------------------------------
// license_plate_recognizer
//
// Purpose:
//   Registered matcher that compares an 8-bit plate code against eight
//   enrolled plate codes on every rising clock edge. It reports:
//   - a one-hot match, with the lowest index winning on duplicates,
//   - an any-match flag,
//   - the encoded index of the matching slot,
//   - a 2-bit status.
//   Optionally it also tracks which plates have already been seen, so that
//   repeat sightings can be flagged.
//
// Ports:
//   clk                 in   1  rising-edge clock
//   rst_n               in   1  asynchronous active-low reset
//   ip_vehicle          in   8  plate code, sampled every rising edge
//   vehicle0..vehicle7  out  1  one-hot registered match per slot
//   detect              out  1  registered OR of vehicle0..7
//   state               out  2  00 IDLE, 01 NEW, 10 REPEAT, 11 UNKNOWN
//   DIST                out  3  encoded index of matched slot, 0 on a miss
//
// Configuration macro:
//   LPR_REPEAT_DETECT_EN - when defined, a sticky per-slot seen register is
//   kept and a repeat sighting reports REPEAT (10). When undefined, every
//   match reports NEW (01).
// ---------------------------------------------------------------------------
module license_plate_recognizer #(
    parameter logic [7:0] PLATE0 = 8'h00,
    parameter logic [7:0] PLATE1 = 8'h49,
    parameter logic [7:0] PLATE2 = 8'h92,
    parameter logic [7:0] PLATE3 = 8'hDB,
    parameter logic [7:0] PLATE4 = 8'h24,
    parameter logic [7:0] PLATE5 = 8'h6D,
    parameter logic [7:0] PLATE6 = 8'hAE,
    parameter logic [7:0] PLATE7 = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ip_vehicle,
    output logic       vehicle0,
    output logic       vehicle1,
    output logic       vehicle2,
    output logic       vehicle3,
    output logic       vehicle4,
    output logic       vehicle5,
    output logic       vehicle6,
    output logic       vehicle7,
    output logic       detect,
    output logic [1:0] state,
    output logic [2:0] DIST
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_NEW     = 2'b01;
    localparam logic [1:0] ST_REPEAT  = 2'b10;
    localparam logic [1:0] ST_UNKNOWN = 2'b11;

    logic [7:0][7:0] plateTab;
    logic [7:0]      rawHit;
    logic            hitFound;
    logic [2:0]      hitIdx;
    logic            alreadySeen;

    logic            relSync_q;
    logic [7:0]      match_q, match_d;
    logic            detect_q, detect_d;
    logic [1:0]      state_q, state_d;
    logic [2:0]      dist_q, dist_d;

    assign plateTab = {PLATE7, PLATE6, PLATE5, PLATE4,
                       PLATE3, PLATE2, PLATE1, PLATE0};

    // Reset release flop. Together with the output registers it forms the
    // two-flop release, so the first evaluation lands on the second rising
    // edge after rst_n goes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relSync_q <= 1'b0;
        end else begin
            relSync_q <= 1'b1;
        end
    end

    // Parallel compare followed by lowest-index priority selection, so that
    // duplicate enrolled codes still produce a strictly one-hot result.
    always_comb begin
        rawHit   = '0;
        hitFound = 1'b0;
        hitIdx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            rawHit[i] = (ip_vehicle == plateTab[i]);
        end
        for (int i = 0; i < 8; i++) begin
            if (rawHit[i] && !hitFound) begin
                hitFound = 1'b1;
                hitIdx   = 3'(i);
            end
        end
    end

`ifdef LPR_REPEAT_DETECT_EN
    logic [7:0] seen_q, seen_d;

    // Seen bits are sticky until reset. They only start collecting once the
    // release flop allows evaluation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= '0;
        end else if (relSync_q) begin
            seen_q <= seen_d;
        end
    end

    always_comb begin
        seen_d      = seen_q | match_d;
        alreadySeen = seen_q[hitIdx];
    end
`else
    assign alreadySeen = 1'b0;
`endif

    always_comb begin
        match_d  = hitFound ? (8'b1 << hitIdx) : 8'b0;
        detect_d = hitFound;
        dist_d   = hitFound ? hitIdx : 3'd0;
        if (!hitFound) begin
            state_d = ST_UNKNOWN;
        end else if (alreadySeen) begin
            state_d = ST_REPEAT;
        end else begin
            state_d = ST_NEW;
        end
    end

    // Output registers hold IDLE/zero until the release flop is set, so
    // IDLE can only be re-entered through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q  <= '0;
            detect_q <= 1'b0;
            state_q  <= ST_IDLE;
            dist_q   <= 3'd0;
        end else if (relSync_q) begin
            match_q  <= match_d;
            detect_q <= detect_d;
            state_q  <= state_d;
            dist_q   <= dist_d;
        end
    end

    assign vehicle0 = match_q[0];
    assign vehicle1 = match_q[1];
    assign vehicle2 = match_q[2];
    assign vehicle3 = match_q[3];
    assign vehicle4 = match_q[4];
    assign vehicle5 = match_q[5];
    assign vehicle6 = match_q[6];
    assign vehicle7 = match_q[7];
    assign detect   = detect_q;
    assign state    = state_q;
    assign DIST     = dist_q;

endmodule

// File: tb/tb_license_plate_recognizer.sv
// ---------------------------------------------------------------------------
// tb_license_plate_recognizer
//
// Directed testbench for license_plate_recognizer. It applies hand-picked
// plate codes and compares every output against hand-computed values.
// Expected REPEAT results follow LPR_REPEAT_DETECT_EN: they become NEW when
// the macro is undefined.
// ---------------------------------------------------------------------------
module tb_license_plate_recognizer;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_NEW     = 2'b01;
    localparam logic [1:0] ST_UNKNOWN = 2'b11;
`ifdef LPR_REPEAT_DETECT_EN
    localparam logic [1:0] ST_REP_EXP = 2'b10;
`else
    localparam logic [1:0] ST_REP_EXP = 2'b01;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] ip_vehicle = 8'h00;
    logic       vehicle0, vehicle1, vehicle2, vehicle3;
    logic       vehicle4, vehicle5, vehicle6, vehicle7;
    logic       detect;
    logic [1:0] state;
    logic [2:0] DIST;

    int vectors = 0;
    int miscompares = 0;

    license_plate_recognizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ip_vehicle(ip_vehicle),
        .vehicle0  (vehicle0),
        .vehicle1  (vehicle1),
        .vehicle2  (vehicle2),
        .vehicle3  (vehicle3),
        .vehicle4  (vehicle4),
        .vehicle5  (vehicle5),
        .vehicle6  (vehicle6),
        .vehicle7  (vehicle7),
        .detect    (detect),
        .state     (state),
        .DIST      (DIST)
    );

    always #5 clk = ~clk;

    // Drive a code on the falling edge, then sample #1 after the rising edge.
    task automatic applyStimulus(input logic [7:0] code);
        @(negedge clk);
        ip_vehicle = code;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expVeh,
                               input logic expDet, input logic [1:0] expState,
                               input logic [2:0] expDist);
        logic [7:0] veh;
        veh = {vehicle7, vehicle6, vehicle5, vehicle4,
               vehicle3, vehicle2, vehicle1, vehicle0};
        vectors++;
        assert (veh === expVeh) else begin
            miscompares++;
            $error("[TB] FAIL %s vehicle got %b expected %b", tag, veh, expVeh);
        end
        vectors++;
        assert (detect === expDet) else begin
            miscompares++;
            $error("[TB] FAIL %s detect got %b expected %b", tag, detect, expDet);
        end
        vectors++;
        assert (state === expState) else begin
            miscompares++;
            $error("[TB] FAIL %s state got %b expected %b", tag, state, expState);
        end
        vectors++;
        assert (DIST === expDist) else begin
            miscompares++;
            $error("[TB] FAIL %s DIST got %0d expected %0d", tag, DIST, expDist);
        end
    endtask

    // Assert reset, release it between edges, and consume the one edge that
    // does not evaluate. The next applyStimulus is then the first evaluation.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        ip_vehicle = 8'h55;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweepCodes [8];
    logic [7:0] unknownCodes [7];
    logic [7:0] repCodes [3];
    logic [2:0] repIdx [3];

    initial begin
        sweepCodes   = '{8'h00, 8'h49, 8'h92, 8'hDB, 8'h24, 8'h6D, 8'hAE, 8'hFF};
        unknownCodes = '{8'h55, 8'h90, 8'h1B, 8'hC3, 8'h66, 8'h0C, 8'h8E};
        repCodes     = '{8'h49, 8'hDB, 8'h6D};
        repIdx       = '{3'd1, 3'd3, 3'd5};

        // Reset held with an enrolled code present on the input.
        ip_vehicle = 8'h49;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_hold", 8'h00, 1'b0, ST_IDLE, 3'd0);

        // Release: first edge stays IDLE, second edge evaluates 8'h49.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_edge1", 8'h00, 1'b0, ST_IDLE, 3'd0);
        @(posedge clk);
        #1;
        checkOutput("release_edge2", 8'h02, 1'b1, ST_NEW, 3'd1);

        // Full enrolment sweep from a clean seen register.
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(sweepCodes[i]);
            checkOutput($sformatf("sweep%0d", i), 8'(1 << i), 1'b1, ST_NEW, 3'(i));
        end

        for (int i = 0; i < 7; i++) begin
            applyStimulus(unknownCodes[i]);
            checkOutput($sformatf("unknown%0d", i), 8'h00, 1'b0, ST_UNKNOWN, 3'd0);
        end

        for (int i = 0; i < 3; i++) begin
            applyStimulus(repCodes[i]);
            checkOutput($sformatf("repeat%0d", i), 8'(1 << repIdx[i]), 1'b1,
                        ST_REP_EXP, repIdx[i]);
        end

        // Hold one code for three cycles from a fresh reset.
        doReset();
        applyStimulus(8'hAE);
        checkOutput("hold0", 8'h40, 1'b1, ST_NEW, 3'd6);
        applyStimulus(8'hAE);
        checkOutput("hold1", 8'h40, 1'b1, ST_REP_EXP, 3'd6);
        applyStimulus(8'hAE);
        checkOutput("hold2", 8'h40, 1'b1, ST_REP_EXP, 3'd6);
        applyStimulus(8'hC3);
        checkOutput("hold_miss", 8'h00, 1'b0, ST_UNKNOWN, 3'd0);
        applyStimulus(8'hAE);
        checkOutput("pre_async", 8'h40, 1'b1, ST_REP_EXP, 3'd6);

        // Asynchronous reset between edges clears the outputs immediately.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_clear", 8'h00, 1'b0, ST_IDLE, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("async_release1", 8'h00, 1'b0, ST_IDLE, 3'd0);
        applyStimulus(8'h49);
        checkOutput("after_async", 8'h02, 1'b1, ST_NEW, 3'd1);
        applyStimulus(8'hAE);
        checkOutput("seen_cleared", 8'h40, 1'b1, ST_NEW, 3'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
